// File: rtl/fir_engine.sv
// fir_engine: run-time configurable FIR core.
// Performs one MAC per cycle against external tap and data RAMs.
// The data RAM is used as a circular sample history.
module fir_engine #(
    parameter  int unsigned pDATA_WIDTH  = 32,
    parameter  int unsigned MAX_TAP_NUM  = 32,
    parameter  int unsigned MAX_DATA_NUM = 1024,
    localparam int unsigned TW           = $clog2(MAX_TAP_NUM),
    localparam int unsigned TNW          = TW + 1,
    localparam int unsigned DNW          = $clog2(MAX_DATA_NUM) + 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    input  logic [TNW-1:0]         tap_num,
    input  logic [DNW-1:0]         data_num,
    output logic [TW-1:0]          tap_A,
    output logic                   tap_EN,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [TW-1:0]          data_A,
    output logic                   data_EN,
    output logic                   data_WE,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
);

    localparam int unsigned W = pDATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_CALC, S_OUT, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [TNW-1:0] tap_num_q, tap_num_d;
    logic [DNW-1:0] data_num_q, data_num_d;
    logic [TNW-1:0] k_q, k_d;
    logic [TW-1:0]  ptr_q, ptr_d;
    logic [DNW-1:0] cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           mac_vld_q, mac_vld_d;
    logic           tlast_q, tlast_d;
    logic           sm_tvalid_q, sm_tvalid_d;
    logic [W-1:0]   sm_tdata_q, sm_tdata_d;
    logic           sm_tlast_q, sm_tlast_d;
    logic           ap_done_q, ap_done_d;
    logic           ap_idle_q, ap_idle_d;
    logic           ss_tready_q, ss_tready_d;

    logic [W-1:0]   prod_c;
    logic [TW-1:0]  rd_addr_c;
    logic           tap_en_c, data_en_c, data_we_c;
    logic [TW-1:0]  tap_a_c, data_a_c;
    logic [W-1:0]   data_di_c;

    // Low W bits of the product are identical for signed and unsigned operands
    assign prod_c = tap_Do * data_Do;

    // History address for tap k: (ptr - k) mod tap_num
    always_comb begin
        if (k_q <= TNW'(ptr_q)) begin
            rd_addr_c = TW'(TNW'(ptr_q) - k_q);
        end else begin
            rd_addr_c = TW'(TNW'(ptr_q) + tap_num_q - k_q);
        end
    end

    // Next-state, datapath and RAM-port decode
    always_comb begin
        state_d     = state_q;
        tap_num_d   = tap_num_q;
        data_num_d  = data_num_q;
        k_d         = k_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        acc_d       = mac_vld_q ? (acc_q + prod_c) : acc_q;
        mac_vld_d   = 1'b0;
        tlast_d     = tlast_q;
        sm_tvalid_d = sm_tvalid_q;
        sm_tdata_d  = sm_tdata_q;
        sm_tlast_d  = sm_tlast_q;
        tap_en_c    = 1'b0;
        tap_a_c     = '0;
        data_en_c   = 1'b0;
        data_we_c   = 1'b0;
        data_a_c    = '0;
        data_di_c   = '0;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    tap_num_d  = tap_num;
                    data_num_d = data_num;
                    k_d        = '0;
                    if (tap_num == '0 || data_num == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                data_en_c = 1'b1;
                data_we_c = 1'b1;
                data_a_c  = TW'(k_q);
                if (k_q == tap_num_q - TNW'(1)) begin
                    state_d = S_WAIT_IN;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + TNW'(1);
                end
            end
            S_WAIT_IN: begin
                if (ss_tvalid) begin
                    data_en_c = 1'b1;
                    data_we_c = 1'b1;
                    data_a_c  = ptr_q;
                    data_di_c = ss_tdata;
                    tlast_d   = ss_tlast;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (k_q != tap_num_q) begin
                    tap_en_c  = 1'b1;
                    tap_a_c   = TW'(k_q);
                    data_en_c = 1'b1;
                    data_a_c  = rd_addr_c;
                    mac_vld_d = 1'b1;
                    k_d       = k_q + TNW'(1);
                end else begin
                    // last product lands in acc_d this cycle
                    state_d     = S_OUT;
                    sm_tvalid_d = 1'b1;
                    sm_tdata_d  = acc_d;
                    sm_tlast_d  = (cnt_q == data_num_q - DNW'(1)) || tlast_q;
                end
            end
            S_OUT: begin
                if (sm_tready) begin
                    sm_tvalid_d = 1'b0;
                    sm_tlast_d  = 1'b0;
                    cnt_d       = cnt_q + DNW'(1);
                    if (TNW'(ptr_q) == tap_num_q - TNW'(1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + TW'(1);
                    end
                    state_d = sm_tlast_q ? S_DONE : S_WAIT_IN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ap_idle_d   = (state_d == S_IDLE);
        ap_done_d   = (state_d == S_DONE);
        ss_tready_d = (state_d == S_WAIT_IN);
    end

    // State and datapath registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            tap_num_q   <= '0;
            data_num_q  <= '0;
            k_q         <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mac_vld_q   <= 1'b0;
            tlast_q     <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            ap_idle_q   <= 1'b1;
            ss_tready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_num_q   <= tap_num_d;
            data_num_q  <= data_num_d;
            k_q         <= k_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mac_vld_q   <= mac_vld_d;
            tlast_q     <= tlast_d;
            sm_tvalid_q <= sm_tvalid_d;
            sm_tdata_q  <= sm_tdata_d;
            sm_tlast_q  <= sm_tlast_d;
            ap_done_q   <= ap_done_d;
            ap_idle_q   <= ap_idle_d;
            ss_tready_q <= ss_tready_d;
        end
    end

    assign ap_done   = ap_done_q;
    assign ap_idle   = ap_idle_q;
    assign ss_tready = ss_tready_q;
    assign sm_tvalid = sm_tvalid_q;
    assign sm_tdata  = sm_tdata_q;
    assign sm_tlast  = sm_tlast_q;
    assign tap_EN    = tap_en_c;
    assign tap_A     = tap_a_c;
    assign data_EN   = data_en_c;
    assign data_WE   = data_we_c;
    assign data_A    = data_a_c;
    assign data_Di   = data_di_c;

endmodule

// File: tb/tb_fir_engine.sv
// tb_fir_engine: scoreboard bench for fir_engine with behavioural FIR model.
module tb_fir_engine;

    localparam int unsigned W   = 32;
    localparam int unsigned MT  = 32;
    localparam int unsigned MD  = 1024;
    localparam int unsigned TW  = 5;
    localparam int unsigned TNW = 6;
    localparam int unsigned DNW = 11;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           ap_start;
    logic           ap_done, ap_idle;
    logic [TNW-1:0] tap_num;
    logic [DNW-1:0] data_num;
    logic [TW-1:0]  tap_A, data_A;
    logic           tap_EN, data_EN, data_WE;
    logic [W-1:0]   tap_Do, data_Di, data_Do;
    logic           ss_tvalid, ss_tlast, ss_tready;
    logic [W-1:0]   ss_tdata;
    logic           sm_tvalid, sm_tlast;
    logic [W-1:0]   sm_tdata;
    logic           sm_tready = 1'b1;

    always #5 aclk = ~aclk;

    fir_engine #(.pDATA_WIDTH(W), .MAX_TAP_NUM(MT), .MAX_DATA_NUM(MD)) dut (
        .aclk(aclk), .aresetn(aresetn), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .tap_num(tap_num), .data_num(data_num),
        .tap_A(tap_A), .tap_EN(tap_EN), .tap_Do(tap_Do),
        .data_A(data_A), .data_EN(data_EN), .data_WE(data_WE),
        .data_Di(data_Di), .data_Do(data_Do),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .ss_tready(ss_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
        .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    // Synchronous single-port RAM models
    logic [W-1:0] tap_mem  [MT];
    logic [W-1:0] data_mem [MT];
    always @(posedge aclk) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A];
        if (data_EN) begin
            if (data_WE) data_mem[data_A] <= data_Di;
            else         data_Do <= data_mem[data_A];
        end
    end

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int bp_mode = 0;
    int stall = 0;
    int tap_v [MT];
    int in_v  [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output ready generation: always ready, fixed 5-cycle stall, or random
    always @(posedge aclk) begin
        #1;
        if (bp_mode == 1) begin
            if (sm_tvalid) begin
                stall++;
                sm_tready = (stall > 5);
            end else begin
                stall = 0;
                sm_tready = 1'b0;
            end
        end else if (bp_mode == 0) begin
            sm_tready = 1'b1;
        end else begin
            sm_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops scoreboard on each output handshake, checks stability under stall
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_data;
    logic         held_last;
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (ap_done) done_cnt++;
            if (sm_tvalid) begin
                check("ss_tready_during_out", 64'(ss_tready), 64'(0));
                if (stall_prev) begin
                    check("stall_tdata", 64'(sm_tdata), 64'(held_data));
                    check("stall_tlast", 64'(sm_tlast), 64'(held_last));
                end
                if (sm_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(sm_tvalid), 64'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sm_tdata", 64'(sm_tdata), 64'(e.data));
                        check("sm_tlast", 64'(sm_tlast), 64'(e.last));
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    held_data  = sm_tdata;
                    held_last  = sm_tlast;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic start(input int ntap, input int ndata);
        int lat;
        @(negedge aclk);
        check("idle_before_start", 64'(ap_idle), 64'(1));
        tap_num  = TNW'(ntap);
        data_num = DNW'(ndata);
        ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
        tap_num  = TNW'($urandom);
        data_num = DNW'($urandom);
        check("idle_low_after_start", 64'(ap_idle), 64'(0));
        if (ntap > 0 && ndata > 0) begin
            lat = 1;
            while (!ss_tready && lat < 200) begin
                @(negedge aclk);
                lat++;
            end
            check("start_latency", 64'(lat), 64'(ntap + 1));
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input int ntap);
        int b;
        int lat;
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = l;
        b = 0;
        while (!ss_tready && b < 2000) begin
            @(negedge aclk);
            b++;
        end
        if (!ss_tready) check("ss_tready_timeout", 64'(ss_tready), 64'(1));
        @(negedge aclk);
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        ss_tdata  = $urandom;
        lat = 1;
        while (!sm_tvalid && lat < 2000) begin
            @(negedge aclk);
            lat++;
        end
        check("sample_latency", 64'(lat), 64'(ntap + 2));
    endtask

    // Full run: model, start, stream inputs, check completion handshake
    task automatic run(input int ntap, input int ndata, input int tl_idx);
        int nout;
        int acc;
        int d0;
        int b;
        exp_t e;
        nout = ndata;
        if (tl_idx >= 0 && tl_idx + 1 < nout) nout = tl_idx + 1;
        for (int n = 0; n < nout; n++) begin
            acc = 0;
            for (int k = 0; k < ntap; k++)
                if (n - k >= 0) acc += tap_v[k] * in_v[n - k];
            e.data = W'(acc);
            e.last = (n == nout - 1);
            exp_q.push_back(e);
        end
        for (int k = 0; k < ntap; k++) tap_mem[k] = W'(tap_v[k]);
        d0 = done_cnt;
        start(ntap, ndata);
        for (int i = 0; i < nout; i++) send(W'(in_v[i]), (i == tl_idx), ntap);
        b = 0;
        while (!ap_done && b < 2000) begin
            @(negedge aclk);
            b++;
        end
        check("ap_done_seen", 64'(ap_done), 64'(1));
        check("idle_low_with_done", 64'(ap_idle), 64'(0));
        @(negedge aclk);
        check("ap_done_one_cycle", 64'(ap_done), 64'(0));
        check("idle_after_done", 64'(ap_idle), 64'(1));
        check("done_pulses", 64'(done_cnt - d0), 64'(1));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic set_basic();
        tap_v[0] = 1; tap_v[1] = 2; tap_v[2] = 3;
        for (int i = 0; i < 5; i++) in_v[i] = i + 1;
    endtask

    logic [49:0] rst_vec;
    localparam logic [49:0] RST_EXP = {1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'h0, 1'b0, 1'b0, 5'h0};

    initial begin
        int d0;
        aresetn = 1'b0; ap_start = 1'b0; tap_num = '0; data_num = '0;
        ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
        for (int i = 0; i < int'(MT); i++) begin
            data_mem[i] = $urandom;
            tap_mem[i]  = $urandom;
        end
        repeat (3) @(negedge aclk);
        rst_vec = {ap_done, ap_idle, ss_tready, sm_tvalid, sm_tdata, sm_tlast, tap_EN, tap_A, data_EN, data_WE, data_A};
        check("reset_state", 64'(rst_vec), 64'(RST_EXP));
        aresetn = 1'b1;

        // Basic
        set_basic();
        run(3, 5, -1);
        // Identity / pointer wrap at tap_num=1
        tap_v[0] = 1; in_v[0] = 7; in_v[1] = -3; in_v[2] = 0; in_v[3] = 9;
        run(1, 4, -1);
        // Back-pressure
        bp_mode = 1;
        set_basic();
        run(3, 5, -1);
        bp_mode = 0;
        // Early tlast then a short run relying on a cleared history
        set_basic();
        run(3, 5, 2);
        in_v[0] = 5; in_v[1] = 5;
        run(3, 2, -1);
        // Overflow truncation
        tap_v[0] = 32'h7FFF_FFFF; in_v[0] = 2;
        run(1, 1, -1);

        // Reset in the middle of CALC
        set_basic();
        for (int k = 0; k < 3; k++) tap_mem[k] = W'(tap_v[k]);
        d0 = done_cnt;
        start(3, 5);
        ss_tvalid = 1'b1; ss_tdata = 32'd1; ss_tlast = 1'b0;
        @(negedge aclk);
        ss_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        rst_vec = {ap_done, ap_idle, ss_tready, sm_tvalid, sm_tdata, sm_tlast, tap_EN, tap_A, data_EN, data_WE, data_A};
        check("reset_mid_calc", 64'(rst_vec), 64'(RST_EXP));
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (8) @(negedge aclk);
        check("no_done_after_abort", 64'(done_cnt - d0), 64'(0));
        run(3, 5, -1);

        // data_num = 0: straight to done, no stream activity
        d0 = done_cnt;
        @(negedge aclk);
        tap_num = TNW'(3); data_num = '0; ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("zero_run_no_ss", 64'(ss_tready), 64'(0));
            check("zero_run_no_sm", 64'(sm_tvalid), 64'(0));
            @(negedge aclk);
        end
        check("zero_run_done", 64'(done_cnt - d0), 64'(1));
        check("zero_run_idle", 64'(ap_idle), 64'(1));

        // Randomized runs with random back-pressure and occasional early tlast
        bp_mode = 2;
        for (int r = 0; r < 8; r++) begin
            int ntap;
            int ndata;
            int tl;
            ntap  = $urandom_range(1, 32);
            ndata = $urandom_range(1, 40);
            tl    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ndata - 1) : -1;
            for (int k = 0; k < ntap; k++) tap_v[k] = $urandom;
            for (int i = 0; i < ndata; i++) in_v[i] = $urandom;
            run(ntap, ndata, tl);
        end
        bp_mode = 0;

        repeat (2) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
